// File: rtl/scan_pkg.sv
// Types and constants shared between the pin scanner and its fault logger.
package scan_pkg;
  localparam int N_PAIR = 86;
  localparam int IDX_W  = 7;

  localparam logic [7:0] FT_OPEN      = 8'h4F;
  localparam logic [7:0] FT_SHORT     = 8'h53;
  localparam logic [7:0] FT_MULTI     = 8'h4D;
  localparam logic [7:0] FT_OPENSHORT = 8'h58;
  localparam logic [7:0] IDX_NONE     = 8'hFF;

  typedef struct packed {
    logic [7:0] ftype;
    logic [7:0] drv;
    logic [7:0] oth;
  } fault_rec_t;

  typedef enum logic [1:0] {SQ_IDLE, SQ_B0, SQ_B1, SQ_B2} seq_state_t;
endpackage

// File: rtl/fault_rec_fifo.sv
// Circular buffer of fault records; extra pointer bit separates full from empty.
module fault_rec_fifo
  import scan_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  fault_rec_t               push_data,
  input  logic                     pop,
  output fault_rec_t               head,
  output fault_rec_t               head_next,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [AW-1:0] IDX_ONE = 1;

  fault_rec_t    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic          do_pop, do_push;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the head slot at the same edge, so a full FIFO still takes the push.
  assign do_push = push && (!full || do_pop);

  assign rd_nxt    = rd_ptr[AW-1:0] + IDX_ONE;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_next = mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/scan_fault_logger.sv
// Classifies walking-zero scan steps, queues 3-byte fault records and streams them out.
module scan_fault_logger
  import scan_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step_valid,
  input  logic [N_PAIR-1:0] expected,
  input  logic [N_PAIR-1:0] observed,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic [15:0]       fault_count,
  output logic [7:0]        drop_count,
  output logic              pattern_err,
  output logic              any_fault
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [N_PAIR-1:0] ONE     = 1;
  localparam logic [CW-1:0]     CNT_ONE = 1;

  logic              srst;
  logic [N_PAIR-1:0] nz;
  logic              one_zero;
  logic [IDX_W-1:0]  d_idx;

  logic              s1_vld;
  logic [IDX_W-1:0]  s1_d;
  logic [N_PAIR-1:0] s1_diff;

  logic [N_PAIR-1:0] others;
  logic              is_open, is_short, multi;
  logic [IDX_W-1:0]  o_idx;
  fault_rec_t        rec;
  logic              push, push_ok;

  seq_state_t        state;
  logic              seq_pop, more;
  fault_rec_t        head, head_next, nxt;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;

  assign srst = rst || clear;

  // Stage 1: locate the driven-low pin; a valid pattern has exactly one zero.
  assign nz       = ~expected;
  assign one_zero = (nz != '0) && ((nz & (nz - ONE)) == '0);

  always_comb begin
    d_idx = '0;
    for (int i = N_PAIR - 1; i >= 0; i--)
      if (nz[i]) d_idx = IDX_W'(i);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      s1_vld  <= 1'b0;
      s1_d    <= '0;
      s1_diff <= '0;
    end else begin
      s1_vld <= step_valid && one_zero;
      if (step_valid) begin
        s1_d    <= d_idx;
        s1_diff <= expected ^ observed;
      end
    end
  end

  // Stage 2: expected[d] is 0, so diff[d] is exactly observed[d].
  assign others   = s1_diff & ~(ONE << s1_d);
  assign is_open  = s1_diff[s1_d];
  assign is_short = |others;
  assign multi    = (others & (others - ONE)) != '0;

  always_comb begin
    o_idx = '0;
    for (int i = N_PAIR - 1; i >= 0; i--)
      if (others[i]) o_idx = IDX_W'(i);
  end

  always_comb begin
    rec.drv = 8'(s1_d);
    rec.oth = is_short ? 8'(o_idx) : IDX_NONE;
    if (is_open) rec.ftype = is_short ? FT_OPENSHORT : FT_OPEN;
    else         rec.ftype = multi ? FT_MULTI : FT_SHORT;
  end

  assign push    = s1_vld && (is_open || is_short);
  assign seq_pop = (state == SQ_B2) && out_ready;
  assign push_ok = push && (!fifo_full || seq_pop);

  fault_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .srst      (srst),
    .push      (push),
    .push_data (rec),
    .pop       (seq_pop),
    .head      (head),
    .head_next (head_next),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      fault_count <= '0;
      drop_count  <= '0;
      pattern_err <= 1'b0;
      any_fault   <= 1'b0;
    end else begin
      if (step_valid && !one_zero) pattern_err <= 1'b1;
      if (push) begin
        any_fault <= 1'b1;
        if (fault_count != 16'hFFFF) fault_count <= fault_count + 16'd1;
        if (!push_ok && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  // After the head pops, the next record is either the second entry or the one arriving now.
  assign more = (fifo_count > CNT_ONE) || push_ok;
  assign nxt  = (fifo_count > CNT_ONE) ? head_next : rec;

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= SQ_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        SQ_IDLE:
          if (!fifo_empty) begin
            state     <= SQ_B0;
            out_valid <= 1'b1;
            out_data  <= head.ftype;
          end
        SQ_B0:
          if (out_ready) begin
            state    <= SQ_B1;
            out_data <= head.drv;
          end
        SQ_B1:
          if (out_ready) begin
            state    <= SQ_B2;
            out_data <= head.oth;
          end
        SQ_B2:
          if (out_ready) begin
            if (more) begin
              state    <= SQ_B0;
              out_data <= nxt.ftype;
            end else begin
              state     <= SQ_IDLE;
              out_valid <= 1'b0;
              out_data  <= '0;
            end
          end
        default: begin
          state     <= SQ_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_scan_fault_logger.sv
// Scoreboard bench: directed scan steps queue hand-computed bytes; a monitor checks the stream.
module tb_scan_fault_logger;
  import scan_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              step_valid = 1'b0;
  logic [N_PAIR-1:0] expected, observed;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready = 1'b0;
  logic [15:0]       fault_count;
  logic [7:0]        drop_count;
  logic              pattern_err, any_fault;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  scan_fault_logger #(.FIFO_DEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .step_valid  (step_valid),
    .expected    (expected),
    .observed    (observed),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .fault_count (fault_count),
    .drop_count  (drop_count),
    .pattern_err (pattern_err),
    .any_fault   (any_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [N_PAIR-1:0] lo(input int k);
    logic [N_PAIR-1:0] v;
    v = '1;
    v[k] = 1'b0;
    return v;
  endfunction

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    sb.push_back(a);
    sb.push_back(b);
    sb.push_back(c);
  endtask

  task automatic step(input logic [N_PAIR-1:0] e, input logic [N_PAIR-1:0] o);
    expected   = e;
    observed   = o;
    step_valid = 1'b1;
    @(posedge clk); #1;
    step_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic drain(input int budget, input bit toggle);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      out_ready = toggle ? (n % 3 != 2) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes pending want 0", sb.size());
    end
  endtask

  // Monitor: compares every accepted byte against the scoreboard and holds stalled data steady.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (out_ready) begin
        prev_stall = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h want none", out_data);
        end else begin
          exp_b = sb.pop_front();
          chk("out_byte", out_data, exp_b);
        end
      end else begin
        if (prev_stall) chk("stall_stable", out_data, prev_data);
        prev_stall = 1'b1;
        prev_data  = out_data;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int n;
    expected = '1;
    observed = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fault_count", fault_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_pattern_err", pattern_err, 0);
    chk("rst_any_fault", any_fault, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // Passing step
    step(lo(5), lo(5));
    idle(6);
    chk("pass_fault_count", fault_count, 0);
    chk("pass_any_fault", any_fault, 0);
    chk("pass_out_valid", out_valid, 0);

    // Open, with latency check: out_valid appears three cycles after the strobe
    push3(8'h4F, 8'h05, 8'hFF);
    step(lo(5), '1);
    @(posedge clk); #1;
    chk("lat_t2_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_t3_valid", out_valid, 1);
    drain(50, 1'b0);
    chk("open_fault_count", fault_count, 1);
    chk("open_any_fault", any_fault, 1);

    push3(8'h53, 8'h05, 8'h09);
    step(lo(5), lo(5) & lo(9));
    drain(50, 1'b0);

    push3(8'h4D, 8'h05, 8'h09);
    step(lo(5), lo(5) & lo(9) & lo(12));
    drain(50, 1'b0);

    push3(8'h58, 8'h03, 8'h28);
    step(lo(3), lo(40));
    drain(50, 1'b0);

    // Back-to-back records stream without a gap through the next-record path
    push3(8'h53, 8'h05, 8'h09);
    push3(8'h58, 8'h03, 8'h28);
    step(lo(5), lo(5) & lo(9));
    step(lo(3), lo(40));
    drain(50, 1'b0);
    chk("b2b_fault_count", fault_count, 6);

    // Bad patterns
    step(lo(2) & lo(7), '1);
    idle(3);
    chk("two_zero_pattern_err", pattern_err, 1);
    chk("two_zero_fault_count", fault_count, 6);
    pulse_clear();
    chk("clr_pattern_err", pattern_err, 0);
    chk("clr_fault_count", fault_count, 0);
    chk("clr_any_fault", any_fault, 0);
    step('1, lo(4));
    idle(4);
    chk("ones_pattern_err", pattern_err, 1);
    chk("ones_fault_count", fault_count, 0);
    chk("ones_out_valid", out_valid, 0);

    // Overflow: 20 open steps back to back with the consumer stalled
    pulse_clear();
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      expected   = lo(k);
      observed   = '1;
      step_valid = 1'b1;
      if (k < 16) push3(8'h4F, 8'(k), 8'hFF);
      @(posedge clk); #1;
    end
    step_valid = 1'b0;
    idle(4);
    chk("ovf_drop_count", drop_count, 4);
    chk("ovf_fault_count", fault_count, 20);
    chk("ovf_out_valid", out_valid, 1);
    chk("ovf_head_byte", out_data, 8'h4F);
    drain(600, 1'b1);

    // Clear while the driven-index byte is presented
    out_ready = 1'b0;
    step(lo(7), '1);
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("mid_rec_valid_seen", out_valid, 1);
    sb.push_back(8'h4F);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("mid_rec_b1_byte", out_data, 8'h07);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_mid_out_valid", out_valid, 0);
    chk("clr_mid_fault_count", fault_count, 0);
    chk("clr_mid_drop_count", drop_count, 0);
    chk("clr_mid_any_fault", any_fault, 0);
    out_ready = 1'b1;
    idle(5);
    chk("clr_mid_abandoned", out_valid, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
